// File: rtl/decoder_2to4_strobe.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_2to4_strobe
//  Purpose  : Registered 2-to-4 one-hot decoder with a valid/ready input
//             handshake. An accepted code drives one of Y3..Y0 high for HOLD
//             cycles. All Y outputs are then low for GAP cycles before the
//             block accepts the next code.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    HOLD      1..255  cycles each one-hot word stays asserted
//    GAP       0..255  all-zero cycles after a word, before the next accept
//  Ports
//    clk       in   1  rising-edge clock
//    rst_n     in   1  asynchronous active-low reset
//    in_valid  in   1  a code is presented on A1,A0
//    in_ready  out  1  block can accept a code (high only in IDLE)
//    A1, A0    in   1  code MSB / LSB, sampled only on a transfer
//    Y3..Y0    out  1  registered one-hot outputs
//    busy      out  1  high whenever the block is not idle
//    code_cnt  out  8  count of accepted codes, wraps modulo 256
// ============================================================================
module decoder_2to4_strobe #(
    parameter int HOLD = 4,
    parameter int GAP  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       A1,
    input  logic       A0,
    output logic       Y3,
    output logic       Y2,
    output logic       Y1,
    output logic       Y0,
    output logic       busy,
    output logic [7:0] code_cnt
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The down-counter is loaded with (length - 1) so that a phase of length N
    // spans exactly N clock edges, including the edge that leaves it.
    localparam logic [7:0] C_HOLD_LOAD = 8'(HOLD - 1);
    // Only used when GAP is nonzero, so the GAP=0 wrap value is never loaded.
    localparam logic [7:0] C_GAP_LOAD  = 8'(GAP - 1);
    localparam bit         C_HAS_GAP   = (GAP != 0);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic [3:0] r_y;
    logic [3:0] w_y_nxt;
    logic [7:0] r_code_cnt;
    logic [7:0] w_code_cnt_nxt;

    logic       w_idle;
    logic       w_transfer;
    logic [3:0] w_onehot;

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    // in_ready comes straight from the state register, so it reads 1 during
    // reset (state forced to IDLE) while the register itself blocks any
    // transfer until rst_n is released.
    assign w_idle     = (r_state == S_IDLE);
    assign w_transfer = in_valid && w_idle;

    // ------------------------------------------------------------------------
    // Code to one-hot mapping. Every 2-bit value is legal, so the word is
    // always exactly one bit set.
    // ------------------------------------------------------------------------
    always_comb begin
        w_onehot = 4'b0001;
        case ({A1, A0})
            2'b00:   w_onehot = 4'b0001;
            2'b01:   w_onehot = 4'b0010;
            2'b10:   w_onehot = 4'b0100;
            2'b11:   w_onehot = 4'b1000;
            default: w_onehot = 4'b0001;
        endcase
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_y_nxt        = r_y;
        w_code_cnt_nxt = r_code_cnt;

        case (r_state)
            S_IDLE: begin
                w_y_nxt = 4'b0000;
                if (w_transfer) begin
                    w_y_nxt        = w_onehot;
                    w_cnt_nxt      = C_HOLD_LOAD;
                    w_code_cnt_nxt = r_code_cnt + 8'd1;
                    w_state_nxt    = S_HOLD;
                end
            end

            S_HOLD: begin
                if (r_cnt != 8'd0) begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end else begin
                    // The word clears on the same edge that leaves HOLD, so
                    // there is no cycle with two Y bits or a stale word.
                    w_y_nxt = 4'b0000;
                    if (C_HAS_GAP) begin
                        w_cnt_nxt   = C_GAP_LOAD;
                        w_state_nxt = S_GAP;
                    end else begin
                        w_cnt_nxt   = 8'd0;
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            S_GAP: begin
                w_y_nxt = 4'b0000;
                if (r_cnt != 8'd0) begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 8'd0;
                w_y_nxt     = 4'b0000;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_y        <= 4'b0000;
            r_code_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_y        <= w_y_nxt;
            r_code_cnt <= w_code_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign in_ready = w_idle;
    assign busy     = !w_idle;
    assign Y3       = r_y[3];
    assign Y2       = r_y[2];
    assign Y1       = r_y[1];
    assign Y0       = r_y[0];
    assign code_cnt = r_code_cnt;

endmodule
`default_nettype wire

// File: tb/tb_decoder_2to4_strobe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decoder_2to4_strobe
//  Purpose  : Self-checking bench for decoder_2to4_strobe. Three instances
//             with different HOLD/GAP settings share one clock; a timing
//             model (cycles elapsed since the last accepted code) predicts
//             every output after every edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_decoder_2to4_strobe;

    logic       clk;
    logic [2:0] rst_n_v;
    logic [2:0] vld_v;
    logic [1:0] code_v [3];

    logic       rdy_a, busy_a, rdy_b, busy_b, rdy_c, busy_c;
    logic [3:0] y_a, y_b, y_c;
    logic [7:0] cnt_a, cnt_b, cnt_c;

    int checks = 0;
    int errors = 0;

    // Reference model: per instance
    int       m_hold [3] = '{4, 1, 8};
    int       m_gap  [3] = '{1, 0, 1};
    bit       m_act  [3];
    int       m_t    [3];
    bit [3:0] m_word [3];
    int       m_cnt  [3];

    decoder_2to4_strobe #(.HOLD(4), .GAP(1)) dut_a (
        .clk(clk), .rst_n(rst_n_v[0]), .in_valid(vld_v[0]), .in_ready(rdy_a),
        .A1(code_v[0][1]), .A0(code_v[0][0]),
        .Y3(y_a[3]), .Y2(y_a[2]), .Y1(y_a[1]), .Y0(y_a[0]),
        .busy(busy_a), .code_cnt(cnt_a)
    );

    decoder_2to4_strobe #(.HOLD(1), .GAP(0)) dut_b (
        .clk(clk), .rst_n(rst_n_v[1]), .in_valid(vld_v[1]), .in_ready(rdy_b),
        .A1(code_v[1][1]), .A0(code_v[1][0]),
        .Y3(y_b[3]), .Y2(y_b[2]), .Y1(y_b[1]), .Y0(y_b[0]),
        .busy(busy_b), .code_cnt(cnt_b)
    );

    decoder_2to4_strobe #(.HOLD(8), .GAP(1)) dut_c (
        .clk(clk), .rst_n(rst_n_v[2]), .in_valid(vld_v[2]), .in_ready(rdy_c),
        .A1(code_v[2][1]), .A0(code_v[2][0]),
        .Y3(y_c[3]), .Y2(y_c[2]), .Y1(y_c[1]), .Y0(y_c[0]),
        .busy(busy_c), .code_cnt(cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector: {in_ready, busy, Y3..Y0, code_cnt}
    function automatic logic [13:0] obs(int d);
        case (d)
            0:       return {rdy_a, busy_a, y_a, cnt_a};
            1:       return {rdy_b, busy_b, y_b, cnt_b};
            default: return {rdy_c, busy_c, y_c, cnt_c};
        endcase
    endfunction

    // Expected vector from the model: the word is visible for the first HOLD
    // cycles after acceptance, the block is busy for HOLD+GAP cycles.
    function automatic logic [13:0] expv(int d);
        logic [3:0] yy;
        yy = (m_act[d] && m_t[d] < m_hold[d]) ? m_word[d] : 4'b0000;
        return {~m_act[d], m_act[d], yy, 8'(m_cnt[d])};
    endfunction

    task automatic model_reset(int d);
        m_act[d] = 1'b0;
        m_t[d]   = 0;
        m_cnt[d] = 0;
    endtask

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            if (!rst_n_v[k]) begin
                model_reset(k);
            end else if (!m_act[k]) begin
                if (vld_v[k]) begin
                    m_act[k]  = 1'b1;
                    m_t[k]    = 0;
                    m_word[k] = 4'b0001 << code_v[k];
                    m_cnt[k]  = (m_cnt[k] + 1) % 256;
                end
            end else begin
                m_t[k]++;
                if (m_t[k] >= m_hold[k] + m_gap[k]) m_act[k] = 1'b0;
            end
        end
    endtask

    // Drive one instance, advance one edge, update model, settle.
    task automatic tick(int d, bit v, logic [1:0] c);
        vld_v[d]  = v;
        code_v[d] = c;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst_n_v = 3'b000;
        for (int k = 0; k < 3; k++) model_reset(k);
        repeat (3) begin
            @(posedge clk);
            model_edge();
            #1;
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs(k) !== 14'b10_0000_00000000)
                $display("FAIL reset_held dut%0d observed=%b required=%b", k, obs(k), 14'b10_0000_00000000);
        end
        rst_n_v = 3'b111;
        @(posedge clk);
        model_edge();
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs(k) !== 14'b10_0000_00000000) begin
                errors++;
                $display("FAIL reset_idle dut%0d observed=%b required=%b", k, obs(k), 14'b10_0000_00000000);
            end
        end
    endtask

    task automatic test_sweep();
        int  last_rise = -1;
        int  idx = 0;
        bit  prev_busy = 1'b0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 6; i++) begin
                tick(0, 1'b1, 2'(c));
                checks++;
                if (obs(0) !== expv(0)) begin
                    errors++;
                    $display("FAIL sweep code=%0d cyc=%0d observed=%b required=%b", c, i, obs(0), expv(0));
                end
                if (busy_a && !prev_busy) begin
                    if (last_rise >= 0) begin
                        checks++;
                        if (idx - last_rise !== 6) begin
                            errors++;
                            $display("FAIL sweep_spacing observed=%0d required=6", idx - last_rise);
                        end
                    end
                    last_rise = idx;
                end
                prev_busy = busy_a;
                idx++;
            end
        end
        tick(0, 1'b0, 2'b00);
        checks++;
        if (cnt_a !== 8'd4) begin
            errors++;
            $display("FAIL sweep_count observed=%0d required=4", cnt_a);
        end
    endtask

    task automatic test_isolation();
        logic [7:0] base;
        base = cnt_a;
        tick(0, 1'b1, 2'b10);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i < 4 && y_a !== 4'b0100) begin
                errors++;
                $display("FAIL iso_hold cyc=%0d observed=%b required=0100", i, y_a);
            end else if (i >= 4 && y_a !== 4'b0000) begin
                errors++;
                $display("FAIL iso_gap cyc=%0d observed=%b required=0000", i, y_a);
            end
            checks++;
            if (obs(0) !== expv(0)) begin
                errors++;
                $display("FAIL iso_model cyc=%0d observed=%b required=%b", i, obs(0), expv(0));
            end
            if (i < 5) tick(0, bit'(i % 2 == 0), 2'($urandom_range(0, 3)));
        end
        tick(0, 1'b0, 2'b00);
        checks++;
        if (cnt_a !== base + 8'd1) begin
            errors++;
            $display("FAIL iso_count observed=%0d required=%0d", cnt_a, base + 8'd1);
        end
    endtask

    task automatic test_min_timing();
        for (int i = 0; i < 8; i++) begin
            tick(1, 1'b1, 2'b11);
            checks++;
            if (y_b !== ((i % 2 == 0) ? 4'b1000 : 4'b0000)) begin
                errors++;
                $display("FAIL min_y cyc=%0d observed=%b required=%b", i, y_b, (i % 2 == 0) ? 4'b1000 : 4'b0000);
            end
            checks++;
            if (obs(1) !== expv(1)) begin
                errors++;
                $display("FAIL min_model cyc=%0d observed=%b required=%b", i, obs(1), expv(1));
            end
        end
        tick(1, 1'b0, 2'b00);
        checks++;
        if (cnt_b !== 8'd4) begin
            errors++;
            $display("FAIL min_count observed=%0d required=4", cnt_b);
        end
    endtask

    task automatic test_reset_mid_hold();
        tick(2, 1'b1, 2'b01);
        for (int i = 0; i < 3; i++) tick(2, 1'b0, 2'b00);
        checks++;
        if (y_c !== 4'b0010) begin
            errors++;
            $display("FAIL midhold_pre observed=%b required=0010", y_c);
        end
        #2;
        rst_n_v[2] = 1'b0;
        model_reset(2);
        #1;
        checks++;
        if (obs(2) !== 14'b10_0000_00000000) begin
            errors++;
            $display("FAIL midhold_async observed=%b required=%b", obs(2), 14'b10_0000_00000000);
        end
        for (int i = 0; i < 3; i++) begin
            tick(2, 1'b1, 2'b11);
            checks++;
            if (obs(2) !== 14'b10_0000_00000000) begin
                errors++;
                $display("FAIL midhold_in_reset cyc=%0d observed=%b required=%b", i, obs(2), 14'b10_0000_00000000);
            end
        end
        rst_n_v[2] = 1'b1;
        tick(2, 1'b1, 2'b10);
        checks++;
        if (y_c !== 4'b0100 || cnt_c !== 8'd1) begin
            errors++;
            $display("FAIL midhold_after observed y=%b cnt=%0d required y=0100 cnt=1", y_c, cnt_c);
        end
        for (int i = 0; i < 10; i++) begin
            tick(2, 1'b0, 2'b00);
            checks++;
            if (obs(2) !== expv(2)) begin
                errors++;
                $display("FAIL midhold_model cyc=%0d observed=%b required=%b", i, obs(2), expv(2));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            tick(0, bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            checks++;
            if (obs(0) !== expv(0)) begin
                errors++;
                $display("FAIL random cyc=%0d observed=%b required=%b", i, obs(0), expv(0));
            end
        end
        tick(0, 1'b0, 2'b00);
    endtask

    task automatic test_wrap();
        #2;
        rst_n_v[1] = 1'b0;
        model_reset(1);
        #1;
        rst_n_v[1] = 1'b1;
        for (int n = 1; n <= 257; n++) begin
            tick(1, 1'b1, 2'($urandom_range(0, 3)));
            checks++;
            if (obs(1) !== expv(1)) begin
                errors++;
                $display("FAIL wrap_model n=%0d observed=%b required=%b", n, obs(1), expv(1));
            end
            if (n == 256 || n == 257) begin
                checks++;
                if (cnt_b !== ((n == 256) ? 8'd0 : 8'd1)) begin
                    errors++;
                    $display("FAIL wrap_count n=%0d observed=%0d required=%0d", n, cnt_b, (n == 256) ? 0 : 1);
                end
            end
            tick(1, 1'b1, 2'($urandom_range(0, 3)));
        end
        tick(1, 1'b0, 2'b00);
    endtask

    // ------------------------------------------------------------------------
    initial begin
        rst_n_v = 3'b000;
        vld_v   = 3'b000;
        for (int k = 0; k < 3; k++) begin
            code_v[k] = 2'b00;
            model_reset(k);
            m_word[k] = 4'b0000;
        end
        #1;
        test_reset();
        test_sweep();
        test_isolation();
        test_random();
        test_min_timing();
        test_reset_mid_hold();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
